conv_window_gen: RTL and testbench

//  Producer side of the convolution window interface: accepts a raster-order 4-bit grayscale

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_line_buffer.sv | 31 +++
 rtl/conv_window_gen.sv | 125 ++++++++++++
 tb/tb_conv_window_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window interface.
// Used by the window generator (producer) and the convolution stage (consumer)
// so both sides agree on pixel width, kernel size and chunk packing.
//   PIX_W      : bits per grayscale pixel
//   KERNEL     : window edge length (KERNEL x KERNEL neighbourhood)
//   CHUNK_W    : width of one packed window
//   chunk_idx  : LSB offset of window cell (r,c) inside a chunk
package conv_pkg;

  localparam int PIX_W   = 4;
  localparam int KERNEL  = 5;
  localparam int CHUNK_W = KERNEL * KERNEL * PIX_W;

  // r = 0 is the oldest line (top), c = 0 the oldest column (left).
  function automatic int chunk_idx(input int r, input int c);
    return (r * KERNEL + c) * PIX_W;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-line pixel memory.
//   clk   : system clock
//   we    : write enable, writes wdata at addr on the rising edge
//   addr  : shared read/write address (pixel column)
//   wdata : pixel to store
//   rdata : combinational read of the current contents at addr
// Because the read is asynchronous, rdata shows the value from the previous
// line while the same-cycle write replaces it for the next line.
module conv_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // No reset: contents are only observed once a full set of lines has been
  // written since the last frame start.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Producer side of the convolution window interface.
// Accepts a raster-order pixel stream, keeps the previous KERNEL-1 lines in
// cascaded line buffers, and emits one KERNEL x KERNEL neighbourhood per valid
// position.
//   clk         : system clock
//   reset       : synchronous, active-high
//   pixel_valid : pixel_in / frame_start are valid this cycle
//   frame_start : qualified by pixel_valid, this pixel is (x=0, y=0)
//   pixel_in    : grayscale pixel
//   data_ready  : one-cycle strobe, data_chunk holds a new window
//   data_chunk  : packed window, cell (r,c) at chunk_idx(r,c)
//
// Handshake: pixel_valid is a pure valid with no ready/backpressure; every
// cycle it is high the pixel is consumed. data_ready is a one-cycle valid
// towards the consumer, which must take data_chunk on that cycle; data_chunk
// stays stable until the next strobe.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic [PIX_W-1:0]   pixel_in,
  output logic               data_ready,
  output logic [CHUNK_W-1:0] data_chunk
);

  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int NLB = KERNEL - 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);

  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  logic [CW-1:0]      cur_col;
  logic [RW-1:0]      cur_row;
  logic [PIX_W-1:0]   lb_rd [NLB];
  logic [PIX_W-1:0]   lb_wd [NLB];
  logic [PIX_W-1:0]   col_vec [KERNEL];
  logic [CHUNK_W-1:0] win_q;
  logic [CHUNK_W-1:0] win_nxt;
  logic               emit;

  // frame_start overrides the counters on the very pixel that carries it,
  // so a restart mid-line or mid-frame takes effect immediately.
  always_comb begin
    cur_col = frame_start ? '0 : col_q;
    cur_row = frame_start ? '0 : row_q;
  end

  // lb0 holds the line just above the current one, lbk the line k+1 above.
  // Each buffer passes its old value down the cascade as it is overwritten.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wd[k] = pixel_in;
    end else begin : g_tail
      assign lb_wd[k] = lb_rd[k-1];
    end

    conv_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .W     (PIX_W)
    ) u_lb (
      .clk   (clk),
      .we    (pixel_valid),
      .addr  (cur_col),
      .wdata (lb_wd[k]),
      .rdata (lb_rd[k])
    );
  end

  // Incoming column, top (oldest line) to bottom (current pixel).
  always_comb begin
    for (int r = 0; r < NLB; r++) col_vec[r] = lb_rd[NLB-1-r];
    col_vec[KERNEL-1] = pixel_in;
  end

  // Shift the window one column left and insert the new column at the right.
  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) begin
        win_nxt[chunk_idx(r, c) +: PIX_W] = win_q[chunk_idx(r, c + 1) +: PIX_W];
      end
      win_nxt[chunk_idx(r, KERNEL - 1) +: PIX_W] = col_vec[r];
    end
  end

  // A window is complete only once KERNEL columns of this line and KERNEL
  // lines of this frame have been seen; this also keeps stale line-buffer
  // contents out of every emitted chunk.
  assign emit = pixel_valid && (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ready <= 1'b0;
      data_chunk <= '0;
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
    end else begin
      data_ready <= emit;
      if (emit) data_chunk <= win_nxt;
      if (pixel_valid) begin
        win_q <= win_nxt;
        if (cur_col == COL_LAST) begin
          col_q <= '0;
          row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col_q <= cur_col + CW'(1);
          row_q <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on an 8x6 image with
// pixel(x,y) = (y*8+x) & 4'hF.
module tb_conv_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pixel_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [3:0]   pixel_in = '0;
  logic         data_ready;
  logic [99:0]  data_chunk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           strobe_cnt = 0;
  logic         mon_en = 1'b0;
  logic         exp_rdy_now = 1'b0;
  logic [99:0]  last_exp = '0;
  logic [99:0]  exp_q[$];

  conv_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .pixel_in    (pixel_in),
    .data_ready  (data_ready),
    .data_chunk  (data_chunk)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [3:0] pix(input int x, input int y);
    int v;
    v = (y * W + x) % 16;
    return v[3:0];
  endfunction

  // Window whose bottom-right cell is pixel (x,y) of the reference image.
  function automatic logic [99:0] model_win(input int x, input int y);
    logic [99:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[(r*5+c)*4 +: 4] = pix(x - 4 + c, y - 4 + r);
    return w;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [99:0] got, input logic [99:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Every cycle: strobe must match the expectation exactly, and data_chunk
  // must equal the most recently expected window (held between strobes).
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_rdy_now && exp_q.size() > 0) last_exp = exp_q.pop_front();
      check("ready", {99'b0, data_ready}, {99'b0, exp_rdy_now});
      check("chunk", data_chunk, last_exp);
      if (data_ready) strobe_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      exp_rdy_now = 1'b0;
      last_exp    = '0;
      pixel_valid = 1'b0;
      frame_start = 1'b0;
    end
    reset = 1'b0;
  endtask

  task automatic idle();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    exp_rdy_now = 1'b0;
  endtask

  task automatic send(input int x, input int y, input logic fs);
    pixel_valid = 1'b1;
    frame_start = fs;
    pixel_in    = pix(x, y);
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    exp_rdy_now = (x >= 4 && y >= 4);
    if (exp_rdy_now) exp_q.push_back(model_win(x, y));
  endtask

  task automatic send_frame(input logic gaps, input logic fs_first, input logic spot);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gaps) repeat ($urandom_range(0, 2)) idle();
        send(x, y, fs_first && x == 0 && y == 0);
        if (spot && x == 4 && y == 4) begin
          check("first_newest", {96'b0, data_chunk[99:96]}, 100'h4);
          check("first_centre", {96'b0, data_chunk[51:48]}, 100'h2);
          check("first_oldest", {96'b0, data_chunk[3:0]}, 100'h0);
        end
      end
    end
    idle();
  endtask

  task automatic end_test(input string tag, input int n_exp);
    check({tag, "_strobes"}, 100'(strobe_cnt), 100'(n_exp));
    check({tag, "_qempty"}, 100'(exp_q.size()), 100'(0));
    strobe_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset and idle
    do_reset(2);
    check("rst_ready", {99'b0, data_ready}, 100'h0);
    check("rst_chunk", data_chunk, 100'h0);
    mon_en = 1'b1;
    repeat (5) idle();
    end_test("t1", 0);

    // 2. one clean frame
    send_frame(1'b0, 1'b1, 1'b1);
    end_test("t2", 8);

    // 3. same frame with random gaps
    send_frame(1'b1, 1'b1, 1'b0);
    end_test("t3", 8);

    // 4. partial frame up to (2,3), frame_start lands where (3,3) would be
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < W; x++)
        if (y < 3 || x < 3) send(x, y, x == 0 && y == 0);
    send_frame(1'b0, 1'b1, 1'b1);
    end_test("t4", 8);

    // 5. reset at pixel (5,4), then restart
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < W; x++)
        if (y < 4 || x < 5) send(x, y, x == 0 && y == 0);
    pixel_valid = 1'b1;
    pixel_in    = pix(5, 4);
    do_reset(1);
    check("mid_rst_ready", {99'b0, data_ready}, 100'h0);
    check("mid_rst_chunk", data_chunk, 100'h0);
    idle();
    send_frame(1'b0, 1'b1, 1'b1);
    end_test("t5", 9);

    // 6. two back-to-back frames, frame_start only on the first
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          send(x, y, f == 0 && x == 0 && y == 0);
    idle();
    end_test("t6", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
